stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Parametrised timing core that replaces the bare up/down counter in the stopwatch top level. It provides start/stop, pause, lap freeze, clear, preset load and countdown-expiry behaviour. Time runs on an N-digit mixed-radix BCD value, for example ss.cc with per-digit moduli. The packed `number` output feeds the existing multiplexed seven-segment display block and LEDs unchanged.

## Interface
- NUMBER_OF_DIGITS, 4, count of 4-bit BCD digits; digit 0 is least significant.
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency.
- TICK_RATE_IN_HZ, 100, rate at which digit 0 advances. DIV = BOARD/TICK must be ≥ 2.
- DIGIT_MODULUS, 16'h6AAA, packed 4 bits per digit. Digit i wraps at modulus i; each value must be in 2..10. The default gives digits 3..0 of 6,10,10,10.

Ports:
- clk  in  1  board clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- lap  in  1  one-cycle pulse; toggles the lap freeze.
- clear  in  1  one-cycle pulse; zeroes the count and returns to IDLE.
- load  in  1  one-cycle pulse; presets the count from load_value.
- load_value  in  4*NUMBER_OF_DIGITS  BCD preset.
- up_down  in  1  level; 1 = count up, 0 = count down. Sampled on each tick.
- number  out  4*NUMBER_OF_DIGITS  displayed value: the lap snapshot while lap_active, otherwise the live count.
- running  out  1  high in RUNNING.
- lap_active  out  1  display frozen on the snapshot.
- expired  out  1  high in EXPIRED.
- wrapped  out  1  one-cycle pulse on up-count rollover.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED. Reset enters IDLE.
- Reset values: count = 0, snapshot = 0, prescaler = 0, number = 0, all flags 0.
- Input priority per cycle: clear > load > start_stop > lap.
- clear, from any state: go to IDLE; count, prescaler and snapshot = 0; lap_active = 0.
- load, accepted in IDLE, PAUSED and EXPIRED; ignored in RUNNING.
  - count = load_value, with each digit ≥ its modulus clamped to modulus-1.
  - State becomes IDLE; prescaler = 0; lap_active = 0.
- start_stop:
  - IDLE → RUNNING, except when up_down = 0 and count = 0, in which case it stays IDLE.
  - RUNNING → PAUSED.
  - PAUSED → RUNNING.
  - EXPIRED: ignored.
- Prescaler counts 0..DIV-1 only in RUNNING. tick = RUNNING and prescaler == DIV-1; the prescaler then returns to 0. The prescaler value is held in PAUSED, so the sub-tick fraction is preserved.
- Up on tick:
  - digit 0 +1. A digit equal to modulus-1 wraps to 0 and carries into the next digit.
  - A carry out of the top digit wraps the count to all-zero and pulses wrapped.
- Down on tick:
  - digit 0 -1. A digit equal to 0 becomes modulus-1 and borrows from the next digit.
  - A tick that makes the count all-zero also moves to EXPIRED. The count stays 0.
- lap:
  - In RUNNING with lap_active = 0: snapshot = live count, lap_active = 1.
  - In any state with lap_active = 1: lap_active = 0.
  - Otherwise ignored.
- The live count keeps running while lap_active.
- start_stop and tick in the same RUNNING cycle: the tick is applied, then the state becomes PAUSED.

## Timing
- All state is registered; there is no combinational path from an input to any output.
- Count, number, flags and wrapped update on the edge that samples the tick or pulse, so they are visible one cycle later.
- After a start from IDLE with prescaler 0, the first count change is visible DIV cycles after the start_stop cycle.
- `number` uses the same timing. Its mux select is the lap_active register.
- expired and running change on the same edge as the final count update.

## Structure
- Package stopwatch_pkg holds:
  - the state enum;
  - DIGIT_WIDTH = 4;
  - a clamp function for load digits;
  - a function computing DIV from the two frequency parameters.
- Sub-module bcd_digit: one digit with parameter MODULUS. Inputs: en, up, clr, ld, ld_val. Outputs: value, carry_out, borrow_out, where carry_out = en & up & value == MODULUS-1. Generated NUMBER_OF_DIGITS times with chained enables.
- The top FSM, prescaler, snapshot register and output mux live in stopwatch_core.

## Test plan
Test plan parameters: BOARD=1000, TICK=100, so DIV=10; 4 digits; moduli 6,10,10,10.
- Reset, up_down=1, start_stop pulse, run 1000 cycles → number = 16'h0100, running = 1.
- Load 16'h5999 in IDLE, start, one tick → number = 16'h0000, wrapped pulses for exactly 1 cycle.
- up_down=0, load 16'h0002, start, 20 cycles → number = 0, expired = 1, running = 0. A further start_stop has no effect.
- Start, lap after 50 cycles (number = 16'h0005), run 100 more cycles → number stays 16'h0005. Second lap → number = 16'h0015.
- Pause after 45 cycles, idle 500 cycles, resume → next change occurs 5 cycles after resume (fraction preserved).
- Load 16'hF9C3 → count = 16'h5993 (digits clamped). clear and start_stop in the same cycle → IDLE with number = 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch timing core.
package stopwatch_pkg;

    localparam int unsigned DIGIT_WIDTH = 4;

    typedef enum logic [1:0] {StIdle, StRunning, StPaused, StExpired} state_e;

    function automatic logic [DIGIT_WIDTH-1:0] clamp_digit(
        input logic [DIGIT_WIDTH-1:0] digit,
        input logic [DIGIT_WIDTH-1:0] max_value
    );
        return (digit > max_value) ? max_value : digit;
    endfunction

    function automatic int unsigned calc_div(
        input int unsigned board_hz,
        input int unsigned tick_hz
    );
        return board_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One mixed-radix BCD digit with wrap-around, carry/borrow outputs and clamped preset.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up,
    input  logic                   clr,
    input  logic                   ld,
    input  logic [DIGIT_WIDTH-1:0] ld_val,
    output logic [DIGIT_WIDTH-1:0] value,
    output logic                   carry_out,
    output logic                   borrow_out
);

    localparam logic [DIGIT_WIDTH-1:0] MAX_VALUE = DIGIT_WIDTH'(MODULUS - 1);

    logic [DIGIT_WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (ld) begin
            value_d = clamp_digit(ld_val, MAX_VALUE);
        end else if (en) begin
            if (up) begin
                value_d = (value_q == MAX_VALUE) ? '0 : value_q + 1'b1;
            end else begin
                value_d = (value_q == '0) ? MAX_VALUE : value_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = en & up & (value_q == MAX_VALUE);
    assign borrow_out = en & ~up & (value_q == '0);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timing core: run/pause FSM, tick prescaler, lap snapshot and BCD digit chain.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS            = 4,
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned TICK_RATE_IN_HZ             = 100,
    parameter logic [4*NUMBER_OF_DIGITS-1:0] DIGIT_MODULUS = 16'h6AAA
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    input  logic                          load,
    input  logic [4*NUMBER_OF_DIGITS-1:0] load_value,
    input  logic                          up_down,
    output logic [4*NUMBER_OF_DIGITS-1:0] number,
    output logic                          running,
    output logic                          lap_active,
    output logic                          expired,
    output logic                          wrapped
);

    localparam int unsigned DIV = calc_div(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_RATE_IN_HZ);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned W   = DIGIT_WIDTH * NUMBER_OF_DIGITS;
    localparam logic [W-1:0] COUNT_ONE = W'(1);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    snap_q, snap_d;
    logic            lap_q, lap_d;
    logic            wrapped_q, wrapped_d;
    logic [W-1:0]    count;
    logic [NUMBER_OF_DIGITS-1:0] digit_en, carry, borrow;
    logic            tick, load_ok, start_eff, expire_hit;
    logic            unused_top_borrow;

    assign tick       = (state_q == StRunning) && (presc_q == PW'(DIV - 1));
    assign load_ok    = load & ~clear & (state_q != StRunning);
    assign expire_hit = tick & ~up_down & (count == COUNT_ONE);
    assign unused_top_borrow = borrow[NUMBER_OF_DIGITS-1];

    // A start from IDLE counting down from zero would expire instantly, so it is refused.
    always_comb begin
        start_eff = 1'b0;
        if (start_stop && !clear && !load_ok) begin
            case (state_q)
                StIdle:    start_eff = up_down || (count != '0);
                StRunning: start_eff = 1'b1;
                StPaused:  start_eff = 1'b1;
                default:   start_eff = 1'b0;
            endcase
        end
    end

    for (genvar i = 0; i < NUMBER_OF_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign digit_en[i] = tick;
        end else begin : g_chain
            assign digit_en[i] = carry[i-1] | borrow[i-1];
        end
        bcd_digit #(
            .MODULUS(int'(DIGIT_MODULUS[i*DIGIT_WIDTH +: DIGIT_WIDTH]))
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .en        (digit_en[i]),
            .up        (up_down),
            .clr       (clear),
            .ld        (load_ok),
            .ld_val    (load_value[i*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .value     (count[i*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .carry_out (carry[i]),
            .borrow_out(borrow[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            snap_q    <= '0;
            lap_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            snap_q    <= snap_d;
            lap_q     <= lap_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Expiry outranks a same-cycle pause request.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        snap_d    = snap_q;
        lap_d     = lap_q;
        wrapped_d = tick & up_down & carry[NUMBER_OF_DIGITS-1] & ~clear;
        if (clear) begin
            state_d = StIdle;
            presc_d = '0;
            snap_d  = '0;
            lap_d   = 1'b0;
        end else if (load_ok) begin
            state_d = StIdle;
            presc_d = '0;
            lap_d   = 1'b0;
        end else begin
            if (state_q == StRunning) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (expire_hit) begin
                state_d = StExpired;
            end else if (start_eff) begin
                state_d = (state_q == StRunning) ? StPaused : StRunning;
            end
            if (lap && !start_eff) begin
                if (lap_q) begin
                    lap_d = 1'b0;
                end else if (state_q == StRunning) begin
                    snap_d = count;
                    lap_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        running    = (state_q == StRunning);
        expired    = (state_q == StExpired);
        lap_active = lap_q;
        wrapped    = wrapped_q;
        number     = lap_q ? snap_q : count;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised and directed bench for stopwatch_core against an integer-valued time model.
module tb_stopwatch_core;

    localparam int unsigned ND   = 4;
    localparam logic [15:0] MODV = 16'h6AAA;
    localparam int          DIV  = 10;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAU = 2, ST_EXP = 3;

    logic        clk = 1'b0;
    logic        rst, start_stop, lap, clear, load, up_down;
    logic [15:0] load_value, number;
    logic        running, lap_active, expired, wrapped;

    int total = 0;
    int bad   = 0;

    // Model: time held as a plain integer in 0..range-1.
    int m_val, m_snap, m_ph, m_st;
    bit m_lap, m_wrap;

    stopwatch_core #(
        .NUMBER_OF_DIGITS           (ND),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .TICK_RATE_IN_HZ            (100),
        .DIGIT_MODULUS              (MODV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .load      (load),
        .load_value(load_value),
        .up_down   (up_down),
        .number    (number),
        .running   (running),
        .lap_active(lap_active),
        .expired   (expired),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    function automatic int modulus(input int i);
        logic [15:0] m;
        m = MODV;
        return int'(m[i*4 +: 4]);
    endfunction

    function automatic int range_total();
        int r = 1;
        for (int i = 0; i < ND; i++) r *= modulus(i);
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] b);
        int v = 0;
        int w = 1;
        for (int i = 0; i < ND; i++) begin
            int d;
            d = int'(b[i*4 +: 4]);
            if (d >= modulus(i)) d = modulus(i) - 1;
            v += d * w;
            w *= modulus(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % modulus(i));
            x = x / modulus(i);
        end
        return r;
    endfunction

    function automatic logic [19:0] model_vec();
        return {to_bcd(m_lap ? m_snap : m_val), m_st == ST_RUN, m_lap, m_st == ST_EXP, m_wrap};
    endfunction

    // Advance the model on the current inputs, clock the DUT, then drop the pulses.
    task automatic step();
        int r, nv, ns;
        bit se;
        r = range_total();
        m_wrap = 1'b0;
        if (rst || clear) begin
            m_st = ST_IDLE; m_val = 0; m_snap = 0; m_ph = 0; m_lap = 1'b0;
        end else if (load && m_st != ST_RUN) begin
            m_st = ST_IDLE; m_val = load_to_int(load_value); m_ph = 0; m_lap = 1'b0;
        end else begin
            nv = m_val;
            ns = m_st;
            if (m_st == ST_RUN) begin
                if (m_ph == DIV - 1) begin
                    m_ph = 0;
                    if (up_down) begin
                        nv = (m_val + 1) % r;
                        m_wrap = (m_val == r - 1);
                    end else begin
                        nv = (m_val + r - 1) % r;
                        if (nv == 0) ns = ST_EXP;
                    end
                end else begin
                    m_ph++;
                end
            end
            se = start_stop && (m_st == ST_RUN || m_st == ST_PAU ||
                                (m_st == ST_IDLE && (up_down || m_val != 0)));
            if (se && ns != ST_EXP) ns = (m_st == ST_RUN) ? ST_PAU : ST_RUN;
            if (lap && !se) begin
                if (m_lap) m_lap = 1'b0;
                else if (m_st == ST_RUN) begin
                    m_snap = m_val;
                    m_lap  = 1'b1;
                end
            end
            m_val = nv;
            m_st  = ns;
        end
        @(posedge clk);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        total += 5;
        if (number !== 16'h0000) begin bad++; $display("FAIL reset_number got=%h want=0000", number); end
        if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        if (lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap got=%b want=0", lap_active); end
        if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired got=%b want=0", expired); end
        if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b want=0", wrapped); end
    endtask

    task automatic test_count_up();
        up_down = 1'b1;
        start_stop = 1'b1;
        step();
        steps(1000);
        total += 2;
        if (number !== 16'h0100) begin bad++; $display("FAIL count_up_number got=%h want=0100", number); end
        if (running !== 1'b1) begin bad++; $display("FAIL count_up_running got=%b want=1", running); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        do_clear();
        load_value = 16'h5999; load = 1'b1; step();
        start_stop = 1'b1; step();
        for (int i = 0; i < 15; i++) begin
            step();
            if (wrapped === 1'b1) pulses++;
        end
        total += 2;
        if (number !== 16'h0000) begin bad++; $display("FAIL wrap_number got=%h want=0000", number); end
        if (pulses != 1) begin bad++; $display("FAIL wrap_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_expire();
        do_clear();
        up_down = 1'b0;
        load_value = 16'h0002; load = 1'b1; step();
        start_stop = 1'b1; step();
        steps(20);
        total += 3;
        if (number !== 16'h0000) begin bad++; $display("FAIL expire_number got=%h want=0000", number); end
        if (expired !== 1'b1) begin bad++; $display("FAIL expire_flag got=%b want=1", expired); end
        if (running !== 1'b0) begin bad++; $display("FAIL expire_running got=%b want=0", running); end
        start_stop = 1'b1; step();
        steps(12);
        total += 2;
        if (expired !== 1'b1 || running !== 1'b0) begin
            bad++; $display("FAIL expire_sticky got=%b%b want=10", expired, running);
        end
        if (number !== 16'h0000) begin bad++; $display("FAIL expire_hold got=%h want=0000", number); end
        up_down = 1'b1;
        do_clear();
    endtask

    task automatic test_lap();
        do_clear();
        start_stop = 1'b1; step();
        steps(50);
        lap = 1'b1; step();
        total += 2;
        if (number !== 16'h0005) begin bad++; $display("FAIL lap_freeze got=%h want=0005", number); end
        if (lap_active !== 1'b1) begin bad++; $display("FAIL lap_active got=%b want=1", lap_active); end
        steps(100);
        total++;
        if (number !== 16'h0005) begin bad++; $display("FAIL lap_hold got=%h want=0005", number); end
        lap = 1'b1; step();
        total += 2;
        if (number !== 16'h0015) begin bad++; $display("FAIL lap_release got=%h want=0015", number); end
        if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_off got=%b want=0", lap_active); end
    endtask

    task automatic test_pause();
        logic [15:0] held;
        int gap = -1;
        do_clear();
        start_stop = 1'b1; step();
        steps(44);
        start_stop = 1'b1; step();
        held = number;
        steps(500);
        total += 2;
        if (number !== 16'h0004 || held !== 16'h0004) begin
            bad++; $display("FAIL pause_hold got=%h/%h want=0004", held, number);
        end
        if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b want=0", running); end
        start_stop = 1'b1; step();
        for (int i = 1; i <= 20 && gap < 0; i++) begin
            step();
            if (number !== held) gap = i;
        end
        total += 2;
        if (gap != 5) begin bad++; $display("FAIL pause_fraction got=%0d want=5", gap); end
        if (number !== 16'h0005) begin bad++; $display("FAIL pause_resume got=%h want=0005", number); end
    endtask

    task automatic test_load_clamp();
        do_clear();
        load_value = 16'hF9C3; load = 1'b1; step();
        total += 2;
        if (number !== 16'h5993) begin bad++; $display("FAIL load_clamp got=%h want=5993", number); end
        if (running !== 1'b0) begin bad++; $display("FAIL load_idle got=%b want=0", running); end
    endtask

    task automatic test_clear_start();
        start_stop = 1'b1; step();
        steps(30);
        clear = 1'b1; start_stop = 1'b1; step();
        steps(15);
        total += 2;
        if (number !== 16'h0000) begin bad++; $display("FAIL clear_start_number got=%h want=0000", number); end
        if (running !== 1'b0) begin bad++; $display("FAIL clear_start_running got=%b want=0", running); end
    endtask

    task automatic test_random();
        int sel;
        logic [19:0] got, want;
        do_clear();
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 3) start_stop = 1'b1;
            else if (sel < 5) lap = 1'b1;
            else if (sel < 6) clear = 1'b1;
            else if (sel < 9) begin
                load = 1'b1;
                case ($urandom_range(0, 2))
                    0:       load_value = 16'($urandom);
                    1:       load_value = {12'h000, 4'($urandom_range(0, 3))};
                    default: load_value = 16'h5990 | 16'($urandom_range(0, 9));
                endcase
            end
            if ($urandom_range(0, 199) == 0) up_down = ~up_down;
            step();
            got  = {number, running, lap_active, expired, wrapped};
            want = model_vec();
            total++;
            if (got !== want) begin
                bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; load = 1'b0;
        up_down = 1'b1; load_value = '0;
        m_val = 0; m_snap = 0; m_ph = 0; m_st = ST_IDLE; m_lap = 1'b0; m_wrap = 1'b0;
        test_reset();
        test_count_up();
        test_wrap();
        test_expire();
        test_lap();
        test_pause();
        test_load_clamp();
        test_clear_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
